arduino_sample_filter: RTL and testbench

Consumes the 16-bit words produced by the Arduino UART receive stage (one-cycle ready strobe per word) and turns them into a clean sensor value for the game/control logic. Each word is range-checked, pushed into a power-of-two circular window, and a running-sum moving average is published. A watchdog declares the link stale if words stop arriving, and the filter flushes so downstream never acts on frozen data.

---
 rtl/arduino_sample_filter_pkg.sv | 19 +
 rtl/arduino_sample_filter_link_watchdog.sv | 33 +++
 rtl/arduino_sample_filter.sv | 107 ++++++++++
 tb/tb_arduino_sample_filter.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/arduino_sample_filter_pkg.sv
// Shared definitions for the Arduino sample filter: state encoding and the
// default range/timeout limits that the sender and receiver sides agree on.
package arduino_sample_filter_pkg;

   typedef enum logic [1:0] {
      ST_EMPTY   = 2'd0,
      ST_FILLING = 2'd1,
      ST_STEADY  = 2'd2,
      ST_STALE   = 2'd3
   } filter_state_t;

   localparam logic [15:0] DEFAULT_MAX_VALUE    = 16'd4000;
   localparam logic [31:0] DEFAULT_TIMEOUT_CLKS = 32'd10_000_000;

   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage

// File: rtl/arduino_sample_filter_link_watchdog.sv
// Link watchdog: counts idle cycles since the last kick and raises a one-cycle
// expired pulse when the count hits TIMEOUT_CLKS-1 without a kick.
module arduino_sample_filter_link_watchdog
   import arduino_sample_filter_pkg::*;
#(
   parameter logic [31:0] TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
   input  logic clk,
   input  logic rst,
   input  logic kick,
   input  logic clear,
   output logic expired
);

   localparam logic [31:0] TERMINAL = TIMEOUT_CLKS - 32'd1;

   logic [31:0] count;

   // clear freezes the counter (link not alive), so it parks at its terminal value after expiry
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (kick) begin
         count <= '0;
      end else if (!clear && (count != TERMINAL)) begin
         count <= count + 32'd1;
      end
   end

   // A kick in the expiry cycle wins, so expiry is suppressed by kick
   assign expired = !kick && !clear && (count == TERMINAL);

endmodule

// File: rtl/arduino_sample_filter.sv
// Range-checks UART words, keeps a power-of-two circular window with a running
// sum, publishes the moving average, and flushes when the link goes stale.
module arduino_sample_filter
   import arduino_sample_filter_pkg::*;
#(
   parameter int          DEPTH_LOG2   = 2,
   parameter logic [15:0] MAX_VALUE    = DEFAULT_MAX_VALUE,
   parameter logic [31:0] TIMEOUT_CLKS = DEFAULT_TIMEOUT_CLKS
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [15:0]   data_in,
   input  logic          data_in_valid,
   output logic [15:0]   avg_out,
   output logic          avg_update,
   output logic          avg_valid,
   output logic          link_alive,
   output logic [7:0]    reject_count,
   output filter_state_t fsm_state
);

   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam int SUM_W = 16 + DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FILL_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

   filter_state_t         state;
   filter_state_t         state_next;
   logic [15:0]           entries [DEPTH];
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [SUM_W-1:0]      sum;
   logic [DEPTH_LOG2:0]   fill;
   logic [DEPTH_LOG2:0]   fill_next;
   logic                  accept;
   logic                  reject;
   logic                  flush;
   logic                  window_full;
   logic                  update_pending;

   assign accept    = data_in_valid && (data_in <= MAX_VALUE);
   assign reject    = data_in_valid && !accept;
   assign fill_next = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;

   arduino_sample_filter_link_watchdog #(
      .TIMEOUT_CLKS(TIMEOUT_CLKS)
   ) u_watchdog (
      .clk    (clk),
      .rst    (rst),
      .kick   (data_in_valid),
      .clear  (!link_alive),
      .expired(flush)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= ST_EMPTY;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = ST_STALE;
      end else if (accept) begin
         state_next = (fill_next == FILL_FULL) ? ST_STEADY : ST_FILLING;
      end
   end

   always_comb begin
      window_full = (state == ST_STEADY);
      fsm_state   = state;
   end

   // Zeroed entries make the subtract-oldest update correct while filling
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
         wr_ptr <= '0;
         sum    <= '0;
         fill   <= '0;
      end else if (accept) begin
         sum             <= sum + SUM_W'(data_in) - SUM_W'(entries[wr_ptr]);
         entries[wr_ptr] <= data_in;
         wr_ptr          <= wr_ptr + 1'b1;
         fill            <= fill_next;
      end
   end

   // Average is taken one edge after the window update, from the new sum
   always_ff @(posedge clk) begin
      if (rst) begin
         update_pending <= 1'b0;
         avg_out        <= '0;
         avg_update     <= 1'b0;
         avg_valid      <= 1'b0;
         link_alive     <= 1'b0;
         reject_count   <= '0;
      end else begin
         update_pending <= accept;
         avg_update     <= update_pending;
         if (update_pending) avg_out <= sum[SUM_W-1:DEPTH_LOG2];
         avg_valid <= flush ? 1'b0 : window_full;
         if (data_in_valid)  link_alive <= 1'b1;
         else if (flush)     link_alive <= 1'b0;
         if (reject) reject_count <= sat_inc8(reject_count);
      end
   end

endmodule

// File: tb/tb_arduino_sample_filter.sv
// Bench for arduino_sample_filter: windowed-average reference model, scoreboard
// queue of expected averages, and a negedge monitor that pops on avg_update.
module tb_arduino_sample_filter;
   import arduino_sample_filter_pkg::*;

   localparam int DEPTH   = 4;
   localparam int TIMEOUT = 100;
   localparam int MAXV    = 4000;

   logic          clk = 1'b0;
   logic          rst;
   logic [15:0]   data_in;
   logic          data_in_valid;
   logic [15:0]   avg_out;
   logic          avg_update;
   logic          avg_valid;
   logic          link_alive;
   logic [7:0]    reject_count;
   filter_state_t fsm_state;

   int n_checks = 0;
   int n_fail   = 0;

   logic [16:0] exp_q[$];
   logic [16:0] mon_e;
   int          win[$];
   bit          m_alive = 0;
   int          m_idle  = 0;
   int          m_rej   = 0;
   int          m_last_avg = 0;
   bit          m_steady_prev = 0;

   arduino_sample_filter #(
      .DEPTH_LOG2  (2),
      .MAX_VALUE   (16'd4000),
      .TIMEOUT_CLKS(32'd100)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .data_in      (data_in),
      .data_in_valid(data_in_valid),
      .avg_out      (avg_out),
      .avg_update   (avg_update),
      .avg_valid    (avg_valid),
      .link_alive   (link_alive),
      .reject_count (reject_count),
      .fsm_state    (fsm_state)
   );

   always #5 clk = ~clk;

   function automatic void check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_fail++;
         $display("FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
      end
   endfunction

   // One clock of stimulus; the model then advances by the same edge
   task automatic step(input bit r, input bit v, input int d);
      bit exp_valid;
      int s;
      rst           = r;
      data_in_valid = v;
      data_in       = 16'(d);
      @(posedge clk);
      #1;
      exp_valid = 0;
      if (r) begin
         win.delete();
         exp_q.delete();
         m_alive    = 0;
         m_idle     = 0;
         m_rej      = 0;
         m_last_avg = 0;
      end else begin
         exp_valid = m_steady_prev;
         if (v) begin
            m_alive = 1;
            m_idle  = 0;
            if (d <= MAXV) begin
               win.push_back(d);
               if (win.size() > DEPTH) void'(win.pop_front());
               s = 0;
               foreach (win[i]) s += win[i];
               m_last_avg = s / DEPTH;
               exp_q.push_back({(win.size() == DEPTH), 16'(m_last_avg)});
            end else if (m_rej < 255) begin
               m_rej++;
            end
         end else if (m_alive) begin
            m_idle++;
            if (m_idle >= TIMEOUT) begin
               m_alive   = 0;
               win.delete();
               exp_valid = 0;
            end
         end
      end
      m_steady_prev = m_alive && (win.size() == DEPTH);
      check("avg_valid", int'(avg_valid), int'(exp_valid));
      check("link_alive", int'(link_alive), int'(m_alive));
      check("reject_count", int'(reject_count), m_rej);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (avg_update === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_update: got avg_out %0d, required no update (t=%0t)", avg_out, $time);
         end else begin
            mon_e = exp_q.pop_front();
            check("avg_out", int'(avg_out), int'(mon_e[15:0]));
            check("avg_valid_at_update", int'(avg_valid), int'(mon_e[16]));
         end
      end
   end

   initial begin
      int fill_vals[4];
      int r;
      fill_vals = '{100, 200, 300, 400};
      rst = 1'b1;
      data_in = '0;
      data_in_valid = 1'b0;

      // Reset, including a strobe coincident with rst that must be dropped
      step(1, 0, 0);
      step(1, 1, 123);
      check("reset_avg_out", int'(avg_out), 0);
      check("reset_avg_update", int'(avg_update), 0);
      check("reset_state", int'(fsm_state), int'(ST_EMPTY));
      idle(2);

      foreach (fill_vals[i]) step(0, 1, fill_vals[i]);
      idle(2);
      step(0, 1, 800);
      step(0, 1, 1);
      idle(2);
      check("steady_state", int'(fsm_state), int'(ST_STEADY));

      step(0, 1, 4001);
      idle(2);
      check("avg_held_after_reject", int'(avg_out), m_last_avg);
      repeat (300) step(0, 1, 5000);

      idle(TIMEOUT);
      check("avg_held_after_timeout", int'(avg_out), m_last_avg);
      check("stale_state", int'(fsm_state), int'(ST_STALE));
      step(0, 1, 40);
      idle(2);

      // Strobe lands exactly on the expiry cycle
      step(0, 1, 1);
      step(0, 1, 2);
      step(0, 1, 3);
      idle(TIMEOUT - 1);
      step(0, 1, 7);
      idle(2);
      check("race_state", int'(fsm_state), int'(ST_STEADY));

      for (int i = 0; i < 800; i++) begin
         r = int'($urandom_range(0, 19));
         if (r == 0) idle(int'($urandom_range(TIMEOUT - 3, TIMEOUT + 3)));
         else if (r < 12) step(0, 1, int'($urandom_range(0, MAXV)));
         else if (r < 14) step(0, 1, int'($urandom_range(MAXV + 1, 65535)));
         else step(0, 0, 0);
      end
      idle(3);

      // Reset in the middle of filling
      step(0, 1, 500);
      step(0, 1, 600);
      step(1, 0, 0);
      check("midreset_avg_out", int'(avg_out), 0);
      check("midreset_state", int'(fsm_state), int'(ST_EMPTY));
      step(0, 1, 8);
      idle(3);

      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
